// File: rtl/mux_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_seq_pkg : shared types and constants for mux_sel_sequencer        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mux_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam int NUM_CH  = 4;
   localparam int SEL_W   = 2;
   localparam int DWELL_W = 8;

   function automatic logic is_last_ch(input logic [SEL_W-1:0] ch);
      return ch == SEL_W'(NUM_CH - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dwell_timer : clear/increment settle counter, terminal at DWELL-1     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dwell_timer
   import mux_seq_pkg::*;
#(
   parameter int DWELL = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_term
);

   localparam logic [DWELL_W-1:0] c_TERM = DWELL_W'(DWELL - 1);

   logic [DWELL_W-1:0] r_cnt;
   logic               w_term;

   assign w_term = (r_cnt == c_TERM);
   assign o_term = w_term;

   // Wraps to zero on its own at terminal so the next channel starts fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr || (i_en && w_term)) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_sel_sequencer : scans a 4:1 mux select and assembles a 4-bit frame|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mux_sel_sequencer
   import mux_seq_pkg::*;
#(
   parameter int DWELL = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                cont,
   input  logic                y_in,
   input  logic                out_ready,
   output logic                s1,
   output logic                s2,
   output logic [NUM_CH-1:0]   out_data,
   output logic                out_valid,
   output logic                busy
);

   state_t              r_state;
   logic [SEL_W-1:0]    r_ch;
   logic [NUM_CH-1:0]   r_shadow;
   logic [NUM_CH-1:0]   r_out_data;
   logic                r_out_valid;
   logic                r_busy;

   logic                w_term;
   logic                w_in_settle;
   logic [NUM_CH-1:0]   w_shadow_nxt;

   assign w_in_settle = (r_state == SETTLE);

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (!w_in_settle),
      .i_en   (w_in_settle),
      .o_term (w_term)
   );

   // Shadow including the sample taken this cycle, so the last channel
   // lands in out_data on the same edge it is captured.
   always_comb begin
      w_shadow_nxt       = r_shadow;
      w_shadow_nxt[r_ch] = y_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ch        <= '0;
         r_shadow    <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= SETTLE;
                  r_ch    <= '0;
                  r_busy  <= 1'b1;
               end
            end

            SETTLE: begin
               if (w_term) begin
                  r_shadow <= w_shadow_nxt;
                  if (is_last_ch(r_ch)) begin
                     r_out_data  <= w_shadow_nxt;
                     r_out_valid <= 1'b1;
                     r_state     <= HOLD;
                  end else begin
                     r_ch <= r_ch + 1'b1;
                  end
               end
            end

            HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_ch        <= '0;
                  if (cont) begin
                     r_state <= SETTLE;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end

            default: begin
               r_state     <= IDLE;
               r_ch        <= '0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign s1        = r_ch[1];
   assign s2        = r_ch[0];
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mux_sel_sequencer : directed bench for DWELL = 2, 1 and 255        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mux_sel_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // DUT A : DWELL = 2
   logic       start_a, cont_a, ready_a, y_a, s1_a, s2_a, valid_a, busy_a;
   logic [3:0] data_a, mux_a;
   assign y_a = mux_a[{s1_a, s2_a}];

   mux_sel_sequencer #(.DWELL(2)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .cont(cont_a), .y_in(y_a),
      .out_ready(ready_a), .s1(s1_a), .s2(s2_a), .out_data(data_a),
      .out_valid(valid_a), .busy(busy_a)
   );

   // DUT B : DWELL = 1
   logic       start_b, cont_b, ready_b, y_b, s1_b, s2_b, valid_b, busy_b;
   logic [3:0] data_b, mux_b;
   assign y_b = mux_b[{s1_b, s2_b}];

   mux_sel_sequencer #(.DWELL(1)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .cont(cont_b), .y_in(y_b),
      .out_ready(ready_b), .s1(s1_b), .s2(s2_b), .out_data(data_b),
      .out_valid(valid_b), .busy(busy_b)
   );

   // DUT C : DWELL = 255
   logic       start_c, cont_c, ready_c, y_c, s1_c, s2_c, valid_c, busy_c;
   logic [3:0] data_c, mux_c;
   assign y_c = mux_c[{s1_c, s2_c}];

   mux_sel_sequencer #(.DWELL(255)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_c), .cont(cont_c), .y_in(y_c),
      .out_ready(ready_c), .s1(s1_c), .s2(s2_c), .out_data(data_c),
      .out_valid(valid_c), .busy(busy_c)
   );

   task automatic pulse_start_a();
      @(negedge clk) start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_a = 0; cont_a = 0; ready_a = 0; mux_a = 4'b0000;
      start_b = 0; cont_b = 0; ready_b = 0; mux_b = 4'b0000;
      start_c = 0; cont_c = 0; ready_c = 0; mux_c = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({s1_a, s2_a, data_a, valid_a, busy_a} !== 8'h00) begin
         bad++; $display("FAIL reset_a: got s=%b data=%b v=%b busy=%b want all 0",
                         {s1_a, s2_a}, data_a, valid_a, busy_a);
      end
      total++;
      if ({s1_b, s2_b, data_b, valid_b, busy_b, s1_c, s2_c, data_c, valid_c, busy_c} !== 16'h0000) begin
         bad++; $display("FAIL reset_bc: got b=%b/%b c=%b/%b want 0",
                         data_b, valid_b, data_c, valid_c);
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_basic();
      mux_a   = 4'b1101;
      ready_a = 1'b1;
      pulse_start_a();
      for (int k = 0; k < 8; k++) begin
         total++;
         if ({s1_a, s2_a} !== 2'(k / 2) || valid_a !== 1'b0 || busy_a !== 1'b1) begin
            bad++; $display("FAIL basic_seq[%0d]: got s=%b v=%b busy=%b want s=%b v=0 busy=1",
                            k, {s1_a, s2_a}, valid_a, busy_a, 2'(k / 2));
         end
         @(posedge clk); #1;
      end
      total++;
      if (valid_a !== 1'b1 || data_a !== 4'b1101 || {s1_a, s2_a} !== 2'b11) begin
         bad++; $display("FAIL basic_frame: got v=%b data=%b s=%b want v=1 data=1101 s=11",
                         valid_a, data_a, {s1_a, s2_a});
      end
      @(posedge clk); #1;
      total++;
      if (valid_a !== 1'b0 || busy_a !== 1'b0 || data_a !== 4'b1101 || {s1_a, s2_a} !== 2'b00) begin
         bad++; $display("FAIL basic_after_hs: got v=%b busy=%b data=%b s=%b want 0 0 1101 00",
                         valid_a, busy_a, data_a, {s1_a, s2_a});
      end
   endtask

   task automatic test_backpressure();
      int lat;
      ready_a = 1'b0;
      pulse_start_a();
      lat = 0;
      while (valid_a !== 1'b1 && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      total++;
      if (lat !== 8) begin
         bad++; $display("FAIL bp_latency: got %0d want 8", lat);
      end
      for (int i = 0; i < 10; i++) begin
         total++;
         if (valid_a !== 1'b1 || data_a !== 4'b1101 || busy_a !== 1'b1) begin
            bad++; $display("FAIL bp_hold[%0d]: got v=%b data=%b busy=%b want 1 1101 1",
                            i, valid_a, data_a, busy_a);
         end
         @(posedge clk); #1;
      end
      ready_a = 1'b1;
      @(posedge clk); #1;
      total++;
      if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
         bad++; $display("FAIL bp_release: got v=%b busy=%b want 0 0", valid_a, busy_a);
      end
   endtask

   task automatic test_busy_start();
      int lat;
      int nvalid;
      mux_a   = 4'b0110;
      ready_a = 1'b1;
      pulse_start_a();
      lat = 0;
      while (valid_a !== 1'b1 && lat < 50) begin
         start_a = (lat == 3);
         @(posedge clk); #1; lat++;
      end
      start_a = 1'b0;
      total++;
      if (lat !== 8 || data_a !== 4'b0110) begin
         bad++; $display("FAIL busy_start_frame: got lat=%0d data=%b want 8 0110", lat, data_a);
      end
      nvalid = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (valid_a === 1'b1 || busy_a === 1'b1) nvalid++;
      end
      total++;
      if (nvalid !== 0) begin
         bad++; $display("FAIL busy_start_queued: got %0d busy/valid cycles want 0", nvalid);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int nvalid;
      mux_a   = 4'b1101;
      ready_a = 1'b0;
      pulse_start_a();
      lat = 0;
      while ({s1_a, s2_a} !== 2'b10 && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      total++;
      if (lat !== 4) begin
         bad++; $display("FAIL rstmid_reach_ch2: got %0d cycles want 4", lat);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({s1_a, s2_a, data_a, valid_a, busy_a} !== 8'h00) begin
         bad++; $display("FAIL rstmid_async: got s=%b data=%b v=%b busy=%b want all 0",
                         {s1_a, s2_a}, data_a, valid_a, busy_a);
      end
      @(negedge clk) rst = 1'b0;
      nvalid = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (valid_a === 1'b1 || busy_a === 1'b1) nvalid++;
      end
      total++;
      if (nvalid !== 0) begin
         bad++; $display("FAIL rstmid_quiet: got %0d busy/valid cycles want 0", nvalid);
      end
      @(negedge clk) rst = 1'b1;
      @(negedge clk) begin rst = 1'b0; start_a = 1'b1; end
      @(posedge clk); #1 start_a = 1'b0;
      total++;
      if (busy_a !== 1'b1) begin
         bad++; $display("FAIL rst_first_start: got busy=%b want 1", busy_a);
      end
      ready_a = 1'b1;
      lat = 0;
      while (valid_a !== 1'b1 && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      total++;
      if (lat !== 8 || data_a !== 4'b1101) begin
         bad++; $display("FAIL rst_first_frame: got lat=%0d data=%b want 8 1101", lat, data_a);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_continuous();
      int lat;
      mux_b   = 4'b1010;
      cont_b  = 1'b1;
      ready_b = 1'b1;
      @(negedge clk) start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      lat = 0;
      while (valid_b !== 1'b1 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      total++;
      if (lat !== 4 || data_b !== 4'b1010) begin
         bad++; $display("FAIL cont_frame1: got lat=%0d data=%b want 4 1010", lat, data_b);
      end
      mux_b = 4'b0101;
      @(posedge clk); #1;
      total++;
      if (valid_b !== 1'b0 || busy_b !== 1'b1 || {s1_b, s2_b} !== 2'b00) begin
         bad++; $display("FAIL cont_no_idle: got v=%b busy=%b s=%b want 0 1 00",
                         valid_b, busy_b, {s1_b, s2_b});
      end
      cont_b = 1'b0;
      lat = 0;
      while (valid_b !== 1'b1 && lat < 20) begin
         if (lat == 2) cont_b = 1'b1;
         total++;
         if (busy_b !== 1'b1) begin
            bad++; $display("FAIL cont_busy[%0d]: got %b want 1", lat, busy_b);
         end
         @(posedge clk); #1; lat++;
      end
      total++;
      if (lat !== 4 || data_b !== 4'b0101) begin
         bad++; $display("FAIL cont_frame2: got lat=%0d data=%b want 4 0101", lat, data_b);
      end
      cont_b = 1'b0;
      @(posedge clk); #1;
      total++;
      if (valid_b !== 1'b0 || busy_b !== 1'b0 || data_b !== 4'b0101) begin
         bad++; $display("FAIL cont_stop: got v=%b busy=%b data=%b want 0 0 0101",
                         valid_b, busy_b, data_b);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy_b !== 1'b0) begin
         bad++; $display("FAIL cont_stays_idle: got busy=%b want 0", busy_b);
      end
   endtask

   task automatic test_long_dwell();
      int lat;
      mux_c   = 4'b0110;
      ready_c = 1'b1;
      @(negedge clk) start_c = 1'b1;
      @(posedge clk); #1 start_c = 1'b0;
      lat = 0;
      while (valid_c !== 1'b1 && lat < 1100) begin
         if (lat == 254 || lat == 255 || lat == 510) begin
            total++;
            if ({s1_c, s2_c} !== 2'(lat / 255)) begin
               bad++; $display("FAIL long_sel[%0d]: got %b want %b",
                               lat, {s1_c, s2_c}, 2'(lat / 255));
            end
         end
         @(posedge clk); #1; lat++;
      end
      total++;
      if (lat !== 1020 || data_c !== 4'b0110) begin
         bad++; $display("FAIL long_frame: got lat=%0d data=%b want 1020 0110", lat, data_c);
      end
      @(posedge clk); #1;
      total++;
      if (valid_c !== 1'b0 || busy_c !== 1'b0) begin
         bad++; $display("FAIL long_release: got v=%b busy=%b want 0 0", valid_c, busy_c);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_busy_start();
      test_reset_mid();
      test_continuous();
      test_long_dwell();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
`default_nettype wire
